// File: rtl/l1_vc_mem_arb_pkg.sv
// Shared types and helpers for the L1 / victim-cache memory port arbiter.
package l1_vc_mem_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arb_state_t;
    typedef enum logic {OWN_L1, OWN_VC} arb_owner_t;

    localparam int unsigned LINE_OFFSET_BITS = 4;
    localparam int unsigned MAX_ADDR_WIDTH   = 64;

    // Callers zero-extend their address; equal tags mean the same cache line.
    function automatic logic [MAX_ADDR_WIDTH-1:0] line_tag(input logic [MAX_ADDR_WIDTH-1:0] addr);
        return addr >> LINE_OFFSET_BITS;
    endfunction

endpackage

// File: rtl/l1_vc_mem_arb_watchdog.sv
// Wait-state watchdog for l1_vc_mem_arbiter: counts S_WAIT cycles and flags expiry.
module l1_vc_mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    output logic expired
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (active && count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th wait cycle.
    assign expired = active && (count == LAST);

endmodule

// File: rtl/l1_vc_mem_arbiter.sv
// Single-outstanding arbiter sharing the line-wide memory port between L1 and victim cache.
// Define L1VC_MEM_ARB_TIMEOUT_EN to build the S_WAIT watchdog and sticky arb_err.
module l1_vc_mem_arbiter
    import l1_vc_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_BYTES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned LINE_WIDTH    = LINE_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  l1_req_valid,
    input  logic                  l1_req_rw,
    input  logic [ADDR_WIDTH-1:0] l1_req_addr,
    input  logic [LINE_WIDTH-1:0] l1_req_wdata,
    output logic                  l1_resp_valid,
    output logic [LINE_WIDTH-1:0] l1_resp_rdata,

    input  logic                  vc_req_valid,
    input  logic                  vc_req_rw,
    input  logic [ADDR_WIDTH-1:0] vc_req_addr,
    input  logic [LINE_WIDTH-1:0] vc_req_wdata,
    output logic                  vc_resp_valid,
    output logic [LINE_WIDTH-1:0] vc_resp_rdata,

    output logic                  mem_req_valid,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [LINE_WIDTH-1:0] mem_resp_rdata,

    output logic                  arb_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t last_owner;
    arb_owner_t grant;
    logic       wd_expired;

    always_comb begin
        grant = OWN_L1;
        if (vc_req_valid && !l1_req_valid) begin
            grant = OWN_VC;
        end else if (vc_req_valid && l1_req_valid) begin
            // Same line: writeback must reach memory before the refill reads it.
            if (line_tag(64'(l1_req_addr)) == line_tag(64'(vc_req_addr))) begin
                grant = OWN_VC;
            end else begin
                grant = (last_owner == OWN_L1) ? OWN_VC : OWN_L1;
            end
        end
    end

`ifdef L1VC_MEM_ARB_TIMEOUT_EN
    logic err_q;

    l1_vc_mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (state == S_ISSUE),
        .active (state == S_WAIT),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == S_WAIT && !mem_resp_valid && wd_expired) begin
            err_q <= 1'b1;
        end
    end

    assign arb_err = err_q;
`else
    assign wd_expired = 1'b0;
    assign arb_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            owner         <= OWN_L1;
            last_owner    <= OWN_L1;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            l1_resp_valid <= 1'b0;
            l1_resp_rdata <= '0;
            vc_resp_valid <= 1'b0;
            vc_resp_rdata <= '0;
        end else begin
            mem_req_valid <= 1'b0;
            l1_resp_valid <= 1'b0;
            vc_resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (l1_req_valid || vc_req_valid) begin
                        owner         <= grant;
                        last_owner    <= grant;
                        mem_req_valid <= 1'b1;
                        state         <= S_ISSUE;
                        if (grant == OWN_VC) begin
                            mem_req_rw    <= vc_req_rw;
                            mem_req_addr  <= vc_req_addr;
                            mem_req_wdata <= vc_req_wdata;
                        end else begin
                            mem_req_rw    <= l1_req_rw;
                            mem_req_addr  <= l1_req_addr;
                            mem_req_wdata <= l1_req_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Response data is staged straight into the owner's output register.
                    if (mem_resp_valid || wd_expired) begin
                        state <= S_RESP;
                        if (owner == OWN_VC) begin
                            vc_resp_valid <= 1'b1;
                            vc_resp_rdata <= (mem_resp_valid && !mem_req_rw) ? mem_resp_rdata : '0;
                        end else begin
                            l1_resp_valid <= 1'b1;
                            l1_resp_rdata <= (mem_resp_valid && !mem_req_rw) ? mem_resp_rdata : '0;
                        end
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_vc_mem_arbiter.sv
// Directed bench for l1_vc_mem_arbiter with a line-granular memory model.
module tb_l1_vc_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          l1_req_valid = 1'b0, l1_req_rw = 1'b0;
    logic [AW-1:0] l1_req_addr = '0;
    logic [LW-1:0] l1_req_wdata = '0;
    logic          l1_resp_valid;
    logic [LW-1:0] l1_resp_rdata;
    logic          vc_req_valid = 1'b0, vc_req_rw = 1'b0;
    logic [AW-1:0] vc_req_addr = '0;
    logic [LW-1:0] vc_req_wdata = '0;
    logic          vc_resp_valid;
    logic [LW-1:0] vc_resp_rdata;
    logic          mem_req_valid, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_wdata;
    logic          mem_resp_valid = 1'b0;
    logic [LW-1:0] mem_resp_rdata = '0;
    logic          arb_err;

    l1_vc_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_BYTES(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .l1_req_valid(l1_req_valid), .l1_req_rw(l1_req_rw), .l1_req_addr(l1_req_addr),
        .l1_req_wdata(l1_req_wdata), .l1_resp_valid(l1_resp_valid), .l1_resp_rdata(l1_resp_rdata),
        .vc_req_valid(vc_req_valid), .vc_req_rw(vc_req_rw), .vc_req_addr(vc_req_addr),
        .vc_req_wdata(vc_req_wdata), .vc_resp_valid(vc_resp_valid), .vc_resp_rdata(vc_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Memory model: unwritten lines read back as the line address repeated four times.
    logic [LW-1:0] mem [logic [AW-1:0]];
    int            cyc = 0;
    int            mem_lat = 1;
    bit            mem_mute = 1'b0;
    int            mem_cnt = 0;
    logic          pend_rw = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [LW-1:0] pend_wdata = '0;
    int            req_cyc[$];
    logic [AW-1:0] req_addr_log[$];
    logic          req_rw_log[$];
    int            l1_pulses = 0;
    int            vc_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0 && !mem_mute) begin
                mem_resp_valid = 1'b1;
                if (pend_rw) begin
                    mem[pend_addr] = pend_wdata;
                    mem_resp_rdata = '1;
                end else begin
                    mem_resp_rdata = mem.exists(pend_addr) ? mem[pend_addr] : {4{pend_addr}};
                end
            end
        end
        if (mem_req_valid === 1'b1) begin
            req_cyc.push_back(cyc);
            req_addr_log.push_back(mem_req_addr);
            req_rw_log.push_back(mem_req_rw);
            pend_rw    = mem_req_rw;
            pend_addr  = mem_req_addr;
            pend_wdata = mem_req_wdata;
            mem_cnt    = mem_lat;
        end
        if (l1_resp_valid === 1'b1) l1_pulses++;
        if (vc_resp_valid === 1'b1) vc_pulses++;
    end

    typedef struct {
        string         name;
        bit            is_vc;
        bit            rw;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] exp_rdata;
        int            lat;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int  n_req = req_cyc.size();
        int  p_l1 = l1_pulses;
        int  p_vc = vc_pulses;
        int  k = 0;
        bit  done = 1'b0;
        @(negedge clk);
        mem_lat = v.lat;
        if (v.is_vc) begin
            vc_req_valid = 1'b1; vc_req_rw = v.rw; vc_req_addr = v.addr; vc_req_wdata = v.wdata;
        end else begin
            l1_req_valid = 1'b1; l1_req_rw = v.rw; l1_req_addr = v.addr; l1_req_wdata = v.wdata;
        end
        while (!done && k < 40) begin
            @(posedge clk); #1; k++;
            if (k == 1) begin
                check({v.name, "_req_valid"}, LW'(mem_req_valid), LW'(1'b1));
                check({v.name, "_req_addr"}, LW'(mem_req_addr), LW'(v.addr));
                check({v.name, "_req_rw"}, LW'(mem_req_rw), LW'(v.rw));
                if (v.rw) check({v.name, "_req_wdata"}, mem_req_wdata, v.wdata);
            end
            if (k == 2) check({v.name, "_req_pulse_end"}, LW'(mem_req_valid), LW'(1'b0));
            if (v.is_vc ? vc_resp_valid : l1_resp_valid) begin
                done = 1'b1;
                check({v.name, "_latency"}, LW'(k), LW'(2 + v.lat));
                check({v.name, "_rdata"}, v.is_vc ? vc_resp_rdata : l1_resp_rdata, v.exp_rdata);
                if (v.is_vc) vc_req_valid = 1'b0;
                else l1_req_valid = 1'b0;
            end
        end
        if (!done) check({v.name, "_resp_wait"}, LW'(1'b0), LW'(1'b1));
        @(posedge clk); #1;
        check({v.name, "_own_pulses"}, LW'(v.is_vc ? vc_pulses - p_vc : l1_pulses - p_l1), LW'(1));
        check({v.name, "_other_pulses"}, LW'(v.is_vc ? l1_pulses - p_l1 : vc_pulses - p_vc), LW'(0));
        check({v.name, "_mem_reqs"}, LW'(req_cyc.size() - n_req), LW'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        l1_req_valid = 1'b0;
        vc_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req_valid"}, LW'(mem_req_valid), '0);
        check({tag, "_mem_req_rw"}, LW'(mem_req_rw), '0);
        check({tag, "_mem_req_addr"}, LW'(mem_req_addr), '0);
        check({tag, "_mem_req_wdata"}, mem_req_wdata, '0);
        check({tag, "_l1_resp_valid"}, LW'(l1_resp_valid), '0);
        check({tag, "_l1_resp_rdata"}, l1_resp_rdata, '0);
        check({tag, "_vc_resp_valid"}, LW'(vc_resp_valid), '0);
        check({tag, "_vc_resp_rdata"}, vc_resp_rdata, '0);
        check({tag, "_arb_err"}, LW'(arb_err), '0);
    endtask

    initial begin
        int n0, p_l1, p_vc, k, l1_done, vc_done;
        logic [LW-1:0] w;
        logic [AW-1:0] exp_addr [4];

        vecs[0] = '{"l1_rd_40", 1'b0, 1'b0, 32'h40, 128'h0, 128'h00000040_00000040_00000040_00000040, 1};
        vecs[1] = '{"vc_wr_100", 1'b1, 1'b1, 32'h100, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 128'h0, 1};
        vecs[2] = '{"l1_rd_100", 1'b0, 1'b0, 32'h100, 128'h0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 2};
        vecs[3] = '{"vc_rd_80", 1'b1, 1'b0, 32'h80, 128'h0, 128'h00000080_00000080_00000080_00000080, 3};
        vecs[4] = '{"l1_wr_40", 1'b0, 1'b1, 32'h40, 128'h11111111_22222222_33333333_44444444, 128'h0, 1};
        vecs[5] = '{"vc_rd_40", 1'b1, 1'b0, 32'h40, 128'h0, 128'h11111111_22222222_33333333_44444444, 2};

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        check("no_err_normal", LW'(arb_err), '0);

        // Same line from both sides: VC write must land before the L1 read.
        w = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
        mem_lat = 1;
        n0 = req_cyc.size();
        @(negedge clk);
        l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h200; l1_req_wdata = '0;
        vc_req_valid = 1'b1; vc_req_rw = 1'b1; vc_req_addr = 32'h200; vc_req_wdata = w;
        l1_done = 0; vc_done = 0; k = 0;
        while (l1_done == 0 && k < 40) begin
            @(posedge clk); #1; k++;
            if (vc_resp_valid) begin
                vc_done++;
                check("same_vc_rdata", vc_resp_rdata, '0);
                vc_req_valid = 1'b0;
            end
            if (l1_resp_valid) begin
                l1_done++;
                check("same_order_vc_first", LW'(vc_done), LW'(1));
                check("same_l1_rdata", l1_resp_rdata, w);
                l1_req_valid = 1'b0;
            end
        end
        if (l1_done == 0) check("same_resp_wait", LW'(1'b0), LW'(1'b1));
        @(posedge clk); #1;
        check("same_mem_reqs", LW'(req_cyc.size() - n0), LW'(2));
        if (req_cyc.size() >= n0 + 2) begin
            check("same_first_rw", LW'(req_rw_log[n0]), LW'(1'b1));
            check("same_second_rw", LW'(req_rw_log[n0+1]), LW'(1'b0));
            check("same_spacing", LW'(req_cyc[n0+1] - req_cyc[n0]), LW'(4));
        end

        // Different lines, both pending twice: VC wins the first tie after reset.
        do_reset();
        mem_lat = 1;
        n0 = req_cyc.size();
        @(negedge clk);
        l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h10;
        vc_req_valid = 1'b1; vc_req_rw = 1'b0; vc_req_addr = 32'h20;
        l1_done = 0; vc_done = 0; k = 0;
        while (l1_done < 2 && k < 60) begin
            @(posedge clk); #1; k++;
            if (vc_resp_valid) begin
                vc_done++;
                check("rr_vc_rdata", vc_resp_rdata, 128'h00000020_00000020_00000020_00000020);
                vc_req_valid = 1'b0;
            end
            if (l1_resp_valid) begin
                l1_done++;
                check("rr_l1_rdata", l1_resp_rdata, 128'h00000010_00000010_00000010_00000010);
                if (l1_done == 1) vc_req_valid = 1'b1;
                else l1_req_valid = 1'b0;
            end
        end
        if (l1_done < 2) check("rr_resp_wait", LW'(1'b0), LW'(1'b1));
        @(posedge clk); #1;
        check("rr_mem_reqs", LW'(req_cyc.size() - n0), LW'(4));
        exp_addr[0] = 32'h20; exp_addr[1] = 32'h10; exp_addr[2] = 32'h20; exp_addr[3] = 32'h10;
        if (req_cyc.size() >= n0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_grant%0d_addr", i), LW'(req_addr_log[n0+i]), LW'(exp_addr[i]));
                if (i > 0) check($sformatf("rr_spacing%0d", i), LW'(req_cyc[n0+i] - req_cyc[n0+i-1]), LW'(4));
            end
        end

        // Reset while a read sits in S_WAIT; the late memory response must be dropped.
        mem_lat = 3;
        n0 = req_cyc.size();
        p_l1 = l1_pulses; p_vc = vc_pulses;
        @(negedge clk);
        l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h300;
        @(posedge clk); #1;
        check("rst_wait_req_valid", LW'(mem_req_valid), LW'(1'b1));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        l1_req_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_wait_l1_pulses", LW'(l1_pulses - p_l1), '0);
        check("rst_wait_vc_pulses", LW'(vc_pulses - p_vc), '0);
        check("rst_wait_mem_reqs", LW'(req_cyc.size() - n0), LW'(1));

`ifdef L1VC_MEM_ARB_TIMEOUT_EN
        // Silent memory: owner still gets a zero-data response after 8 wait cycles.
        do_reset();
        mem_mute = 1'b1;
        mem_lat = 1;
        @(negedge clk);
        l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h500;
        l1_done = 0; k = 0;
        while (l1_done == 0 && k < 40) begin
            @(posedge clk); #1; k++;
            if (k == 9) check("to_err_before", LW'(arb_err), '0);
            if (l1_resp_valid) begin
                l1_done++;
                check("to_latency", LW'(k), LW'(10));
                check("to_rdata", l1_resp_rdata, '0);
                check("to_err_set", LW'(arb_err), LW'(1'b1));
                l1_req_valid = 1'b0;
            end
        end
        if (l1_done == 0) check("to_resp_wait", LW'(1'b0), LW'(1'b1));
        repeat (5) @(posedge clk);
        #1;
        check("to_err_sticky", LW'(arb_err), LW'(1'b1));
        mem_mute = 1'b0;
        do_reset();
        @(posedge clk); #1;
        check("to_err_cleared", LW'(arb_err), '0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
